if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction fetch stage; the producer end of the decode interface. It keeps the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small in-order queue. It presents {instr, instr_pc} to decode under a valid/ready handshake. Redirects from branch/jump resolution flush the queue and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries (power of 2, >=2); also the max in-flight requests

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, registered
imem_addr  out  32  word address of the request (bits [1:0]=0), registered
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses arrive in request order
imem_rdata  in  32  response instruction word
redirect_valid  in  1  taken branch/jump/jr: restart fetch
redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced 0)
instr_valid  out  1  queue head valid to decode
instr  out  32  queue head instruction word
instr_pc  out  32  address of the queue head instruction
instr_ready  in  1  decode accepts head (0 = stall)

Behaviour:
- Reset (async, reset_n=0): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue empty, outstanding=0, discard=0, state=RUN, fetch_pc=RESET_PC.
- Credit rule: a request is issued only when count+outstanding < QDEPTH. The queue therefore never overflows. Overflow is an assertion failure.
- Request handshake: imem_req and imem_addr stay stable until imem_gnt. On req&gnt: outstanding+1, fetch_pc+=4, and the next request is presented the following cycle if credit allows.
- fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Response: imem_rvalid with outstanding=0 is an assertion failure. If discard>0, the response is dropped and discard-1. Otherwise the word is pushed with its PC (per-request PC FIFO) and outstanding-1.
- Latency: gnt at cycle t, earliest rvalid at t+1, instr_valid at t+2. There is no bypass.
- Output: instr/instr_pc/instr_valid reflect the queue head. instr_valid&instr_ready pops the entry. Push and pop in the same cycle are allowed at any occupancy.
- Redirect at cycle t, effective at t+1:
  - queue flushed; instr_valid=0 at t+1
  - fetch_pc=redirect_pc
  - discard=outstanding, including a request granted in cycle t
  - an un-granted pending request is withdrawn, and imem_req drops at t+1
  - redirect has priority over pop, push and gnt bookkeeping
- States:
  - RUN: issue per credit rule.
  - DRAIN: entered on redirect with discard>0. Requests are allowed per the credit rule, with discarded responses counted against credit. Returns to RUN when discard reaches 0.
  - Redirect during DRAIN: discard=outstanding again. Never lose count.
- First request is presented the cycle after reset deassertion.

Decomposition:
- Package if_pkg:
  - fetch state enum {RUN, DRAIN}
  - RESET_PC default constant
  - PC_STEP=4
  - typedef fetch_entry_t {instr[31:0], pc[31:0]}
- Sub-module if_instr_fifo: parameterized QDEPTH, fetch_entry_t payload, push/pop/flush/count, synchronous flush, async reset. It is instantiated for the instruction queue; the in-flight PC tag FIFO reuses it.
- Top holds fetch_pc, request register, outstanding/discard counters and the FSM.

Test Plan:
- Reset release, memory gnt=1 always and rvalid one cycle after gnt, instr_ready=1 -> imem_addr 0,4,8,... on successive cycles; instr_valid from cycle 3; instr_pc matches each word.
- instr_ready=0 for 10 cycles -> exactly QDEPTH (2) grants; imem_req then 0; queue holds PC 0,4; on release it drains in order with no loss.
- gnt withheld 3 cycles with req=1 -> imem_addr constant at 0x0; no outstanding increment until gnt.
- Two requests in flight (0x10, 0x14), redirect_pc=0x200 -> both responses dropped; next instr_valid carries instr_pc=0x200; state DRAIN->RUN after the second drop.
- Redirect coinciding with gnt and pop -> granted response discarded, queue empty next cycle, next fetch addr=redirect_pc.
- redirect_pc=0xFFFFFFFC -> following fetch addr 0x00000000; reset_n asserted mid-flight -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_instr_fifo.sv
// In-order queue of fetch entries with synchronous flush; QDEPTH must be a power of 2.
module if_instr_fifo
  import if_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  output fetch_entry_t                   head,
  output logic [$clog2(QDEPTH+1)-1:0]    count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  fetch_entry_t     mem_q [QDEPTH];
  fetch_entry_t     mem_d [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over push/pop in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(QDEPTH));

  assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty && !flush));

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: credit-limited word requests to imem, in-order response queue to decode, redirect flush.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             imem_req_q, imem_req_d;
  logic [31:0]      imem_addr_q, imem_addr_d;
  // outstanding counts every request in flight, discarded ones included
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] q_count_next;
  logic             credit_ok;

  logic             grant;
  logic             resp_drop;
  logic             q_push, q_pop;
  fetch_entry_t     q_wdata, q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_empty, q_full;

  logic             tag_push;
  fetch_entry_t     tag_wdata, tag_head;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_count_unused;
  logic             tag_full_unused;
  logic [31:0]      tag_instr_unused;

  assign grant     = imem_req_q & imem_gnt;
  assign resp_drop = imem_rvalid & (state_q == DRAIN);
  assign q_push    = imem_rvalid & ~resp_drop & ~redirect_valid;
  assign q_pop     = ~q_empty & instr_ready & ~redirect_valid;
  assign tag_push  = grant & ~redirect_valid;

  assign tag_wdata        = '{instr: 32'h0, pc: imem_addr_q};
  assign q_wdata          = '{instr: imem_rdata, pc: tag_head.pc};
  assign tag_instr_unused = tag_head.instr;

  if_instr_fifo #(
    .QDEPTH (QDEPTH)
  ) u_instr_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // PC tags of live (non-discarded) requests, popped as their words land in the queue.
  if_instr_fifo #(
    .QDEPTH (QDEPTH)
  ) u_tag_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (tag_push),
    .push_data (tag_wdata),
    .pop       (q_push),
    .head      (tag_head),
    .count     (tag_count_unused),
    .empty     (tag_empty),
    .full      (tag_full_unused)
  );

  // Counters, fetch PC and request register; redirect overrides all normal bookkeeping.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    discard_d     = discard_q - CNT_W'(resp_drop);
    fetch_pc_d    = grant ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
    q_count_next  = q_count + CNT_W'(q_push) - CNT_W'(q_pop);
    imem_req_d    = 1'b0;

    if (redirect_valid) begin
      discard_d    = outstanding_d;
      fetch_pc_d   = align_word(redirect_pc);
      q_count_next = '0;
    end

    unique case (state_q)
      RUN: begin
        if (redirect_valid && (outstanding_d != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (discard_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    credit_ok = (SUM_W'(q_count_next) + SUM_W'(outstanding_d)) < SUM_W'(QDEPTH);

    if (redirect_valid) begin
      imem_req_d = 1'b0;
    end else if (imem_req_q && !imem_gnt) begin
      imem_req_d = 1'b1;
    end else begin
      imem_req_d = credit_ok;
    end

    imem_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = ~q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;

  assert property (@(posedge clk) disable iff (!reset_n) !(imem_rvalid && (outstanding_q == '0)));
  assert property (@(posedge clk) disable iff (!reset_n) !(q_push && q_full && !q_pop));
  assert property (@(posedge clk) disable iff (!reset_n) !(q_push && tag_empty));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and random checks of if_fetch_unit against a program-order fetch model and a simple memory model.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int QD = 2;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mresp_t;

  mresp_t      mem_q[$];
  int          total, bad;
  int          cyc, grants, pops, resp_cnt, live;
  int          gnt_mode, rdy_mode, lat_fix;
  logic [31:0] exp_pc, exp_fetch;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_modes(input int g, input int r, input int l);
    gnt_mode    = g;
    rdy_mode    = r;
    lat_fix     = l;
    imem_gnt    = (g == 2) ? 1'($urandom_range(0, 1)) : 1'(g);
    instr_ready = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
  endtask

  // One clock: update the model from what happens at the coming edge, then drive the next cycle.
  task automatic cycle();
    logic        req, gnt, rv, iv, rdy, rd;
    logic [31:0] addr, ipc, ins, rpc;
    req  = imem_req;
    addr = imem_addr;
    gnt  = imem_gnt;
    rv   = imem_rvalid;
    iv   = instr_valid;
    ipc  = instr_pc;
    ins  = instr;
    rdy  = instr_ready;
    rd   = redirect_valid;
    rpc  = {redirect_pc[31:2], 2'b00};

    if (req && gnt) begin
      check("grant_addr", addr, exp_fetch);
      check("credit", 32'(live < QD), 32'd1);
      mem_q.push_back('{addr: addr, due: cyc + ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3)))});
      exp_fetch = exp_fetch + 32'd4;
      live++;
      grants++;
    end
    if (rv) begin
      void'(mem_q.pop_front());
      resp_cnt++;
    end
    if (iv && rdy && !rd) begin
      check("instr_pc", ipc, exp_pc);
      check("instr_word", ins, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      live--;
      pops++;
    end
    if (rd) begin
      exp_pc    = rpc;
      exp_fetch = rpc;
      live      = 0;
    end

    @(posedge clk);
    #1;
    cyc++;

    if (rd) begin
      check("flush_valid", 32'(instr_valid), 32'd0);
      check("redirect_req_drop", 32'(imem_req), 32'd0);
    end

    redirect_valid = 1'b0;
    imem_gnt       = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(gnt_mode);
    instr_ready    = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // Asynchronous reset: outputs must reach reset values without a clock edge.
  task automatic do_reset();
    reset_n        = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    mem_q.delete();
    exp_pc    = 32'h0;
    exp_fetch = 32'h0;
    live      = 0;
    gnt_mode  = 0;
    rdy_mode  = 0;
    lat_fix   = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int g0, r0;
    total = 0; bad = 0; cyc = 0; grants = 0; pops = 0; resp_cnt = 0; live = 0;
    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    @(posedge clk);
    #1;

    // Streaming from reset: first request at RESET_PC, first word two cycles after its grant.
    do_reset();
    set_modes(1, 1, 1);
    cycle();
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    cycle();
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_no_valid_yet", 32'(instr_valid), 32'd0);
    cycle();
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_pc0", instr_pc, 32'h0);
    p_run(20);

    // Decode stalled: exactly QD grants, then requests stop and the queue holds 0,4.
    do_reset();
    set_modes(1, 0, 1);
    g0 = grants;
    p_run(10);
    check("t2_grants", 32'(grants - g0), 32'(QD));
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_head_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc0", instr_pc, 32'h0);
    set_modes(1, 1, 1);
    cycle();
    check("t2_head_pc4", instr_pc, 32'h4);
    r0 = pops;
    p_run(10);
    check("t2_drained", 32'(pops - r0 >= 3), 32'd1);

    // Grant withheld: request and address hold steady.
    do_reset();
    set_modes(0, 1, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      check("t3_req_hold", 32'(imem_req), 32'd1);
      check("t3_addr_hold", imem_addr, 32'h0);
      check("t3_no_valid", 32'(instr_valid), 32'd0);
      cycle();
    end
    set_modes(1, 1, 1);
    cycle();
    cycle();
    check("t3_valid_after_gnt", 32'(instr_valid), 32'd1);
    check("t3_pc", instr_pc, 32'h0);

    // Two in flight then redirect: both responses discarded, DRAIN until the second drop.
    do_reset();
    set_modes(1, 1, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cycle();
    g0 = grants;
    for (int i = 0; i < 20 && (grants - g0) < 2; i++) cycle();
    check("t4_two_inflight", 32'(grants - g0), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    check("t4_state_drain", 32'(dut.state_q), 32'(DRAIN));
    r0 = resp_cnt;
    for (int i = 0; i < 20 && (resp_cnt - r0) < 2; i++) cycle();
    check("t4_state_run", 32'(dut.state_q), 32'(RUN));
    for (int i = 0; i < 30 && !instr_valid; i++) cycle();
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_pc200", instr_pc, 32'h200);
    p_run(10);

    // Redirect in the same cycle as a grant and a pop.
    do_reset();
    set_modes(1, 1, 1);
    for (int i = 0; i < 20 && !(imem_req && instr_valid); i++) cycle();
    check("t5_setup", 32'(imem_req && instr_valid), 32'd1);
    check("t5_gnt_pop", 32'(imem_gnt && instr_ready), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycle();
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    check("t5_next_addr", imem_addr, 32'h300);
    for (int i = 0; i < 10 && !instr_valid; i++) cycle();
    check("t5_first_pc", instr_pc, 32'h300);

    // Wrap past the top of the address space, then reset while requests are in flight.
    do_reset();
    set_modes(1, 1, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    check("t6_wrap_req", 32'(imem_req), 32'd1);
    check("t6_wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 10 && !instr_valid; i++) cycle();
    check("t6_top_pc", instr_pc, 32'hFFFF_FFFC);
    p_run(3);
    do_reset();

    // Random grants, stalls, latencies and redirects.
    set_modes(2, 2, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      cycle();
    end
    check("rand_progress", 32'(pops > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic p_run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

endmodule
